mux16_rr_sched: RTL and testbench

Round-robin scheduler that shares the 16:1 single-bit multiplexer among 16 requesters. It owns the mux select lines `s3..s0`, grants one requester at a time for a bounded burst, and registers the selected data bit into a validated serial output stream. It sits between the requesting sources and the downstream serial consumer, replacing hand-driven select sequencing.

---
 rtl/mux16_pkg.sv | 35 +++
 rtl/mux16_mux16.sv | 32 +++
 rtl/mux16_rr_sched.sv | 116 +++++++++++
 tb/tb_mux16_rr_sched.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mux16_pkg.sv
// Shared definitions for the 16-requester round-robin mux scheduler:
// FSM encoding, sizes and the cyclic priority search.
package mux16_pkg;

  localparam int N_REQ = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Lowest offset from ptr wins; scanning high-to-low lets the nearest hit overwrite.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [SEL_W-1:0] ptr);
    pick_t            p;
    logic [SEL_W-1:0] i;
    p.found = 1'b0;
    p.idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      i = ptr + SEL_W'(k);
      if (req[i]) begin
        p.found = 1'b1;
        p.idx   = i;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux16_mux16.sv
// Combinational 16:1 single-bit multiplexer; {s3,s2,s1,s0} picks d<n>.
module mux16 (
  output logic op,
  input  logic s3,
  input  logic s2,
  input  logic s1,
  input  logic s0,
  input  logic d15,
  input  logic d14,
  input  logic d13,
  input  logic d12,
  input  logic d11,
  input  logic d10,
  input  logic d9,
  input  logic d8,
  input  logic d7,
  input  logic d6,
  input  logic d5,
  input  logic d4,
  input  logic d3,
  input  logic d2,
  input  logic d1,
  input  logic d0
);

  logic [15:0] dv;

  assign dv = {d15, d14, d13, d12, d11, d10, d9, d8,
               d7, d6, d5, d4, d3, d2, d1, d0};
  assign op = dv[{s3, s2, s1, s0}];

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler owning the mux16 select lines: grants one requester
// for up to BURST transfers and registers the selected bit into op/valid.
module mux16_rr_sched
  import mux16_pkg::*;
#(
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] d,
  output logic [N_REQ-1:0] gnt,
  output logic             s3,
  output logic             s2,
  output logic             s1,
  output logic             s0,
  output logic             op,
  output logic             valid,
  output logic             busy,
  output state_t           fsm_state
);

  localparam int CNT_W = ($clog2(BURST + 1) < 1) ? 1 : $clog2(BURST + 1);

  // Handshake: valid is a one-cycle qualifier on op with no back-pressure;
  // op holds its last transferred bit whenever valid is low.

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               drain_q, drain_d;
  logic               op_q, op_d;
  logic               valid_q, valid_d;
  logic               mux_out;
  logic               rearb;
  pick_t              pick;

  mux16 u_mux (
    .op  (mux_out),
    .s3  (sel_q[3]), .s2 (sel_q[2]), .s1 (sel_q[1]), .s0 (sel_q[0]),
    .d15 (d[15]), .d14 (d[14]), .d13 (d[13]), .d12 (d[12]),
    .d11 (d[11]), .d10 (d[10]), .d9  (d[9]),  .d8  (d[8]),
    .d7  (d[7]),  .d6  (d[6]),  .d5  (d[5]),  .d4  (d[4]),
    .d3  (d[3]),  .d2  (d[2]),  .d1  (d[1]),  .d0  (d[0])
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      drain_q <= 1'b0;
      op_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      op_q    <= op_d;
      valid_q <= valid_d;
    end
  end

  // drain marks that the last burst transfer is done; the following edge is
  // the arbitration edge, giving one valid-low cycle at every grant switch.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    op_d    = op_q;
    valid_d = 1'b0;
    rearb   = 1'b0;
    pick    = rr_pick(req, ptr_q);

    case (state_q)
      IDLE: rearb = 1'b1;
      SERVE: begin
        if (drain_q || !req[sel_q]) begin
          rearb = 1'b1;
        end else begin
          op_d    = mux_out;
          valid_d = 1'b1;
          if (cnt_q == '0) drain_d = 1'b1;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      default: rearb = 1'b1;
    endcase

    if (rearb) begin
      drain_d = 1'b0;
      if (pick.found) begin
        state_d = SERVE;
        sel_d   = pick.idx;
        ptr_d   = pick.idx + 1'b1;
        cnt_d   = CNT_W'(BURST - 1);
      end else begin
        state_d = IDLE;
      end
    end
  end

  assign gnt       = (state_q == SERVE) ? (N_REQ'(1) << sel_q) : '0;
  assign {s3, s2, s1, s0} = sel_q;
  assign op        = op_q;
  assign valid     = valid_q;
  assign busy      = (state_q == SERVE);
  assign fsm_state = state_q;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Bench for mux16_rr_sched: directed scenarios plus random traffic, checked
// each cycle against a burst-counting reference model through an expected queue.
module tb_mux16_rr_sched;
  import mux16_pkg::*;

  localparam int BURST = 4;
  localparam int EW    = 23;  // {gnt[15:0], sel[3:0], busy, valid, op}

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic [15:0] d;
  logic [15:0] gnt;
  logic        s3, s2, s1, s0;
  logic        op, valid, busy;
  state_t      fsm_state;

  logic [EW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // reference model: current grant (-1 idle), transfers remaining, pointer
  int   m_cur = -1;
  int   m_rem = 0;
  int   m_ptr = 0;
  int   m_sel = 0;
  logic m_op  = 1'b0;
  logic m_val = 1'b0;

  mux16_rr_sched #(.BURST(BURST)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .d         (d),
    .gnt       (gnt),
    .s3        (s3),
    .s2        (s2),
    .s1        (s1),
    .s0        (s0),
    .op        (op),
    .valid     (valid),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_edge(input logic r, input logic [15:0] rq, input logic [15:0] dd);
    int c;
    if (r) begin
      m_cur = -1; m_rem = 0; m_ptr = 0; m_sel = 0; m_op = 1'b0; m_val = 1'b0;
    end else if (m_cur >= 0 && m_rem > 0 && rq[m_cur]) begin
      m_op  = dd[m_cur];
      m_val = 1'b1;
      m_rem = m_rem - 1;
    end else begin
      m_val = 1'b0;
      m_cur = -1;
      for (int k = 0; k < 16; k++) begin
        c = (m_ptr + k) % 16;
        if (m_cur < 0 && rq[c]) m_cur = c;
      end
      if (m_cur >= 0) begin
        m_sel = m_cur;
        m_ptr = (m_cur + 1) % 16;
        m_rem = BURST;
      end
    end
  endtask

  task automatic step(input logic r, input logic [15:0] rq, input logic [15:0] dd);
    logic [15:0] g;
    @(negedge clk);
    rst = r; req = rq; d = dd;
    @(posedge clk);
    model_edge(r, rq, dd);
    g = (m_cur >= 0) ? (16'd1 << m_cur) : 16'd0;
    exp_q.push_back({g, 4'(m_sel), (m_cur >= 0), m_val, m_op});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    logic [EW-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gnt",   32'(gnt),                 32'(e[22:7]));
      chk("sel",   32'({s3, s2, s1, s0}),    32'(e[6:3]));
      chk("busy",  32'(busy),                32'(e[2]));
      chk("valid", 32'(valid),               32'(e[1]));
      chk("op",    32'(op),                  32'(e[0]));
      chk("state", 32'(fsm_state == SERVE),  32'(e[2]));
    end
  end

  initial begin
    logic [15:0] rq;
    rst = 1'b1; req = '0; d = '0;

    // single requester: 4 transfers, one arbitration cycle, re-grant
    step(1, 16'h0000, 16'h0000);
    step(1, 16'h0000, 16'h0000);
    for (int i = 0; i < 14; i++) step(0, 16'h0001, 16'h0001);

    // round-robin 0,1,15 with wrap back to 0
    step(1, 16'h0000, 16'h0000);
    for (int i = 0; i < 28; i++) step(0, 16'h8003, 16'($urandom));

    // early withdrawal of requester 5 after 2 transfers, 9 pending
    step(1, 16'h0000, 16'h0000);
    step(0, 16'h0220, 16'hFFFF);
    step(0, 16'h0220, 16'hFFFF);
    step(0, 16'h0220, 16'hFFFF);
    for (int i = 0; i < 7; i++) step(0, 16'h0200, 16'h0000);

    // data routing with every requester active
    step(1, 16'h0000, 16'h0000);
    for (int i = 0; i < 82; i++) step(0, 16'hFFFF, 16'hA5C3);

    // reset during second transfer of requester 3, then 0 must win
    step(1, 16'h0000, 16'h0000);
    step(0, 16'h0008, 16'h0008);
    step(0, 16'h0008, 16'h0008);
    step(1, 16'h0009, 16'h0008);
    for (int i = 0; i < 6; i++) step(0, 16'h0009, 16'h0009);

    // idle return: select holds last value
    for (int i = 0; i < 5; i++) step(0, 16'h0000, 16'h0000);

    // random traffic with occasional resets
    rq = 16'h0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0:       rq = 16'h0000;
          1:       rq = 16'd1 << $urandom_range(0, 15);
          default: rq = 16'($urandom & $urandom);
        endcase
      end
      step(($urandom_range(0, 79) == 0), rq, 16'($urandom));
    end

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left unchecked", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
